// File: rtl/pal_pkg.sv
// pal_pkg -- shared definitions for the registered PAL array.
//   Bitstream geometry (length and plane base offsets), per-field bit-index
//   helpers, and the configuration FSM state encoding.
package pal_pkg;

  typedef enum logic [1:0] {
    PAL_IDLE   = 2'd0,
    PAL_SHIFT  = 2'd1,
    PAL_COMMIT = 2'd2
  } pal_state_e;

  // Total bitstream length: AND plane + OR plane + two macrocell bits/output.
  function automatic int pal_cfg_len(input int ni, input int nt, input int no);
    return 2*ni*nt + nt*no + 2*no;
  endfunction

  function automatic int pal_or_base(input int ni, input int nt);
    return 2*ni*nt;
  endfunction

  function automatic int pal_mc_base(input int ni, input int nt, input int no);
    return pal_or_base(ni, nt) + nt*no;
  endfunction

  // neg=0 selects the true literal, neg=1 the complemented literal.
  function automatic int pal_and_idx(input int ni, input int t, input int i, input int neg);
    return 2*(t*ni + i) + neg;
  endfunction

  function automatic int pal_or_idx(input int ni, input int nt, input int o, input int t);
    return pal_or_base(ni, nt) + o*nt + t;
  endfunction

  function automatic int pal_regsel_idx(input int ni, input int nt, input int no, input int o);
    return pal_mc_base(ni, nt, no) + 2*o;
  endfunction

  function automatic int pal_inv_idx(input int ni, input int nt, input int no, input int o);
    return pal_mc_base(ni, nt, no) + 2*o + 1;
  endfunction

endpackage

// File: rtl/pal_macrocell.sv
// pal_macrocell -- one output macrocell: optional register stage and
// registered/combinational output select.
//   clk, rst_n : clock, async active-low reset
//   s          : sum-of-products (already inverted as configured)
//   reg_sel    : 1 = drive registered q, 0 = drive s directly
//   run        : register update enable
//   clear      : synchronous clear of q (takes priority over run)
//   out        : macrocell output
module pal_macrocell (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic reg_sel,
  input  logic run,
  input  logic clear,
  output logic out
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= 1'b0;
    else if (clear) q <= 1'b0;
    else if (run)   q <= s;
  end

  assign out = reg_sel ? q : s;

endmodule

// File: rtl/pal_reg_array.sv
// pal_reg_array -- programmable AND/OR array with a serially loaded,
// double-buffered configuration and per-output macrocells.
//   clk, rst_n  : clock, async active-low reset
//   cfg_valid   : accept cfg_bit on this edge
//   cfg_bit     : serial configuration bit (first bit ends up at index 0)
//   cfg_clear   : abort a load in progress (shadow contents kept)
//   run         : enables macrocell register updates
//   pal_in      : logic inputs
//   pal_out     : logic outputs (0 until a configuration is committed)
//   cfg_done    : one-cycle pulse in the cycle after the final bit is taken
//   cfg_loaded  : an active configuration exists
//   cfg_bit_out : readback bit (shadow[0] as it is shifted out)
// Build option: define PAL_READBACK_EN to build the readback flop; without it
// cfg_bit_out is tied low.
module pal_reg_array
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_TERMS   = 8,
  parameter int NUM_OUTPUTS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  input  logic                   cfg_clear,
  input  logic                   run,
  input  logic [NUM_INPUTS-1:0]  pal_in,
  output logic [NUM_OUTPUTS-1:0] pal_out,
  output logic                   cfg_done,
  output logic                   cfg_loaded,
  output logic                   cfg_bit_out
);

  localparam int L  = pal_cfg_len(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  localparam logic [1:0] ST_IDLE   = PAL_IDLE;
  localparam logic [1:0] ST_SHIFT  = PAL_SHIFT;
  localparam logic [1:0] ST_COMMIT = PAL_COMMIT;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [L-1:0]  shadow, active, shadow_nxt;
  logic          accept, commit;

  assign shadow_nxt = {cfg_bit, shadow[L-1:1]};
  // COMMIT ignores both cfg_valid and cfg_clear.
  assign accept = cfg_valid && !cfg_clear && (state != ST_COMMIT);
  // Edge that takes the final bit: active and macrocells update here so the
  // new function is visible in the same cycle cfg_done is high.
  assign commit = accept && (state == ST_SHIFT) && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      shadow     <= '0;
      active     <= '0;
      cfg_done   <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_clear) count <= '0;
          else if (accept) begin
            shadow <= shadow_nxt;
            count  <= CW'(1);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cfg_clear) begin
            count <= '0;
            state <= ST_IDLE;
          end else if (accept) begin
            shadow <= shadow_nxt;
            if (commit) begin
              count      <= '0;
              active     <= shadow_nxt;
              cfg_done   <= 1'b1;
              cfg_loaded <= 1'b1;
              state      <= ST_COMMIT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // AND plane
  logic [NUM_TERMS-1:0] term;
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [NUM_INPUTS-1:0] en_t, en_c;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lit
      assign en_t[i] = active[pal_and_idx(NUM_INPUTS, t, i, 0)];
      assign en_c[i] = active[pal_and_idx(NUM_INPUTS, t, i, 1)];
    end
    // Empty term must read 0, not the vacuous AND of nothing.
    assign term[t] = (|(en_t | en_c)) & ~|(en_t & ~pal_in) & ~|(en_c & pal_in);
  end

  // OR plane + macrocells
  logic [NUM_OUTPUTS-1:0] s, mc_out;
  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    logic [NUM_TERMS-1:0] conn;
    for (genvar t = 0; t < NUM_TERMS; t++) begin : g_conn
      assign conn[t] = active[pal_or_idx(NUM_INPUTS, NUM_TERMS, o, t)];
    end
    assign s[o] = (|(term & conn)) ^ active[pal_inv_idx(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS, o)];

    pal_macrocell u_mc (
      .clk     (clk),
      .rst_n   (rst_n),
      .s       (s[o]),
      .reg_sel (active[pal_regsel_idx(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS, o)]),
      .run     (run & cfg_loaded),
      .clear   (commit),
      .out     (mc_out[o])
    );
  end

  assign pal_out = cfg_loaded ? mc_out : '0;

`ifdef PAL_READBACK_EN
  logic rb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rb_q <= 1'b0;
    else if (accept) rb_q <= shadow[0];
  end
  assign cfg_bit_out = rb_q;
`else
  logic unused_shadow_lsb;
  assign unused_shadow_lsb = shadow[0];
  assign cfg_bit_out = 1'b0;
`endif

endmodule
